simple_gan_dense_engine: RTL and testbench



---
 rtl/simple_gan_dense_engine.sv | 192 +++++++++++++++++++
 tb/tb_simple_gan_dense_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/simple_gan_dense_engine.sv
// -----------------------------------------------------------------------------
// simple_gan_dense_engine
//
// Evaluates one fully connected Simple GAN layer by streaming weights and
// biases from a synchronous ROM (one-cycle read latency). For each output
// neuron j it accumulates sum_k x[k] * w[j*N_IN+k] (Q8.8 x Q1.7 -> Q9.15),
// rescales to Q8.8 with an arithmetic shift (floor), adds the Q8.8 bias and
// saturates to 16 bits. All outputs are published together with a one-cycle
// done pulse; y_out otherwise holds the previous layer result.
//
// Build option:
//   SIMPLE_GAN_DENSE_RELU_EN  defined     -> ReLU after saturation (hidden layers)
//                             not defined -> linear saturated output
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   begin an evaluation (sampled only while idle)
//   x_in    N_IN Q8.8 signed inputs, element k at [16k+15:16k], captured at start
//   w_addr  weight ROM address, row-major j*N_IN+k
//   w_data  Q1.7 signed weight, valid one cycle after w_addr
//   b_addr  bias ROM address (current neuron j)
//   b_data  Q8.8 signed bias, valid one cycle after b_addr
//   busy    high from start acceptance until done
//   done    one-cycle pulse, y_out valid from this cycle
//   y_out   N_OUT Q8.8 signed outputs, element j at [16j+15:16j]
// -----------------------------------------------------------------------------
module simple_gan_dense_engine #(
  parameter int N_IN  = 9,
  parameter int N_OUT = 3,
  parameter int W_AW  = 5,
  parameter int B_AW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*N_IN-1:0]    x_in,
  output logic [W_AW-1:0]       w_addr,
  input  logic [7:0]            w_data,
  output logic [B_AW-1:0]       b_addr,
  input  logic [15:0]           b_data,
  output logic                  busy,
  output logic                  done,
  output logic [16*N_OUT-1:0]   y_out
);

  // k runs 0..N_IN: the extra step absorbs the ROM read latency.
  localparam int KW = $clog2(N_IN + 1);

  typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

  state_t               state, state_nxt;
  logic [KW-1:0]        k;
  logic [B_AW-1:0]      j;
  logic signed [31:0]   acc;
  logic signed [15:0]   x_reg [N_IN];
  logic signed [15:0]   res   [N_OUT];

  logic                 last_k, last_j;
  logic [W_AW-1:0]      row_base;
  logic signed [15:0]   x_sel;
  logic signed [23:0]   prod;
  logic signed [32:0]   acc_sh, b_ext, wb_sum;
  logic signed [15:0]   r_sat, r_out;

  assign last_k   = (int'(k) == N_IN);
  assign last_j   = (int'(j) == N_OUT - 1);
  assign row_base = W_AW'(int'(j) * N_IN);
  assign busy     = (state != IDLE);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and ROM addresses
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    state_nxt = state;
    w_addr    = '0;
    b_addr    = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = MAC;
      end
      MAC: begin
        b_addr = j;
        // The final MAC step only consumes data, so the address holds.
        w_addr = last_k ? row_base + W_AW'(N_IN - 1) : row_base + W_AW'(k);
        if (last_k) state_nxt = WB;
      end
      WB: begin
        b_addr    = j;
        w_addr    = row_base + W_AW'(N_IN - 1);
        state_nxt = last_j ? IDLE : MAC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  always_comb begin
    // w_data arriving at step k belongs to the address issued at step k-1.
    x_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(k) == i + 1) x_sel = x_reg[i];
    end
    prod = 24'(x_sel) * 24'($signed(w_data));

    // Q9.15 -> Q8.8 by dropping 7 fraction bits; arithmetic shift floors.
    acc_sh = {{8{acc[31]}}, acc[31:7]};
    b_ext  = {{17{b_data[15]}}, b_data};
    wb_sum = acc_sh + b_ext;

    if (wb_sum > 33'sd32767)       r_sat = 16'sh7FFF;
    else if (wb_sum < -33'sd32768) r_sat = 16'sh8000;
    else                           r_sat = wb_sum[15:0];

`ifdef SIMPLE_GAN_DENSE_RELU_EN
    r_out = r_sat[15] ? 16'sh0000 : r_sat;
`else
    r_out = r_sat;
`endif
  end

  // ---------------------------------------------------------------------------
  // Control/accumulator registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      j     <= '0;
      k     <= '0;
      done  <= 1'b0;
      y_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            j   <= '0;
            k   <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          if (k != '0) acc <= acc + 32'(prod);
          if (!last_k) k <= k + KW'(1);
        end
        WB: begin
          acc <= '0;
          if (last_j) begin
            done <= 1'b1;
            // The last neuron's result is still on r_out this cycle.
            for (int i = 0; i < N_OUT; i++) begin
              y_out[16*i +: 16] <= (i == N_OUT - 1) ? r_out : res[i];
            end
          end else begin
            j <= j + B_AW'(1);
            k <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand and per-neuron result storage
  // ---------------------------------------------------------------------------
  // NOTE: these arrays are always written before they are read in a run, so
  // they carry no reset; y_out is the only architecturally visible copy.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < N_IN; i++) x_reg[i] <= x_in[16*i +: 16];
    end
    if (state == WB) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (int'(j) == i) res[i] <= r_out;
      end
    end
  end

endmodule

// File: tb/tb_simple_gan_dense_engine.sv
// -----------------------------------------------------------------------------
// Self-checking bench for simple_gan_dense_engine (default 9 -> 3 geometry).
// A synchronous ROM model feeds weights/biases; expected outputs come from a
// plain-arithmetic reference of the layer equation. Outputs are sampled on
// the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_simple_gan_dense_engine;

  localparam int N_IN  = 9;
  localparam int N_OUT = 3;
  localparam int W_AW  = 5;
  localparam int B_AW  = 2;
  localparam int PER_N = N_IN + 2;
  localparam int TOTAL = N_OUT * PER_N;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [16*N_IN-1:0]   x_in;
  logic [W_AW-1:0]      w_addr;
  logic [7:0]           w_data;
  logic [B_AW-1:0]      b_addr;
  logic [15:0]          b_data;
  logic                 busy;
  logic                 done;
  logic [16*N_OUT-1:0]  y_out;

  logic signed [7:0]    w_rom [2**W_AW];
  logic signed [15:0]   b_rom [2**B_AW];
  logic [16*N_OUT-1:0]  prev_y;

  int n_checks = 0;
  int n_errors = 0;

  simple_gan_dense_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .W_AW(W_AW), .B_AW(B_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .busy(busy), .done(done), .y_out(y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: one-cycle read latency.
  always @(posedge clk) begin
    w_data <= w_rom[w_addr];
    b_data <= b_rom[b_addr];
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rom(input int w, input int b, input bit rnd);
    for (int i = 0; i < 2**W_AW; i++) w_rom[i] = rnd ? 8'($urandom) : 8'(w);
    for (int i = 0; i < 2**B_AW; i++) b_rom[i] = rnd ? 16'($urandom) : 16'(b);
  endtask

  // Reference: y_j = clamp(floor(sum_k x_k*w_jk / 128) + b_j), optional ReLU.
  function automatic logic [16*N_OUT-1:0] model(input logic [16*N_IN-1:0] x);
    logic [16*N_OUT-1:0] y;
    longint acc, v;
    y = '0;
    for (int jn = 0; jn < N_OUT; jn++) begin
      acc = 0;
      for (int kn = 0; kn < N_IN; kn++)
        acc += longint'($signed(x[16*kn +: 16])) * longint'(w_rom[jn*N_IN + kn]);
      v = (acc >>> 7) + longint'(b_rom[jn]);
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
`ifdef SIMPLE_GAN_DENSE_RELU_EN
      if (v < 0) v = 0;
`endif
      y[16*jn +: 16] = 16'(v);
    end
    return y;
  endfunction

  function automatic logic [16*N_IN-1:0] rand_x();
    logic [16*N_IN-1:0] x;
    for (int i = 0; i < N_IN; i++) x[16*i +: 16] = 16'($urandom);
    return x;
  endfunction

  // Called at a falling edge with the DUT idle. Returns at the falling edge
  // of the done cycle when hold_start=1 (so the next call chains directly),
  // otherwise one cycle later after checking that done was a single pulse.
  task automatic run_layer(input string tag, input logic [16*N_IN-1:0] x, input bit hold_start);
    logic [16*N_OUT-1:0] exp_y;
    int addr_err, ctrl_err, jj, mm, exp_w;
    exp_y    = model(x);
    addr_err = 0;
    ctrl_err = 0;
    start    = 1'b1;
    x_in     = x;
    for (int c = 0; c <= TOTAL; c++) begin
      @(negedge clk);
      x_in  = ~x;                                 // must be ignored once captured
      start = hold_start || (c == 5) || (c == 20); // pulses while busy are ignored
      if (c < TOTAL) begin
        jj = c / PER_N;
        mm = c % PER_N;
        if (busy !== 1'b1 || done !== 1'b0) ctrl_err++;
        if (b_addr !== B_AW'(jj)) addr_err++;
        if (mm <= N_IN) begin
          exp_w = jj * N_IN + ((mm < N_IN) ? mm : N_IN - 1);
          if (w_addr !== W_AW'(exp_w)) addr_err++;
        end
        if (c == TOTAL - 1) check({tag, "_y_hold"}, 48'(y_out), 48'(prev_y));
      end
    end
    check({tag, "_done"}, 48'(done), 48'd1);
    check({tag, "_busy_at_done"}, 48'(busy), 48'd0);
    check({tag, "_ctrl_during_run"}, 48'(ctrl_err), 48'd0);
    check({tag, "_addr_trace"}, 48'(addr_err), 48'd0);
    for (int i = 0; i < N_OUT; i++)
      check($sformatf("%s_y%0d", tag, i), 48'(y_out[16*i +: 16]), 48'(exp_y[16*i +: 16]));
    prev_y = exp_y;
    if (!hold_start) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 48'(done), 48'd0);
    end
  endtask

  initial begin
    logic [16*N_IN-1:0] x;

    rst_n  = 1'b0;
    start  = 1'b0;
    x_in   = '0;
    prev_y = '0;
    set_rom(0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy",   48'(busy),   48'd0);
    check("rst_done",   48'(done),   48'd0);
    check("rst_y",      48'(y_out),  48'd0);
    check("rst_w_addr", 48'(w_addr), 48'd0);
    check("rst_b_addr", 48'(b_addr), 48'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unit weights: 9 * 1.0 * 0.5 = 4.5 -> 0x0480
    set_rom(64, 0, 1'b0);
    x = {N_IN{16'h0100}};
    run_layer("basic", x, 1'b0);
    check("basic_const", 48'(y_out), 48'({N_OUT{16'h0480}}));

    // Positive saturation
    set_rom(127, 16'h7FFF, 1'b0);
    x = {N_IN{16'h7FFF}};
    run_layer("sat_hi", x, 1'b0);
    check("sat_hi_const", 48'(y_out), 48'({N_OUT{16'h7FFF}}));

    // Negative saturation (ReLU clamps to zero)
    set_rom(-128, 0, 1'b0);
    run_layer("sat_lo", x, 1'b0);
`ifdef SIMPLE_GAN_DENSE_RELU_EN
    check("sat_lo_const", 48'(y_out), 48'({N_OUT{16'h0000}}));
`else
    check("sat_lo_const", 48'(y_out), 48'({N_OUT{16'h8000}}));
`endif

    // Floor rounding of the rescale: -1>>>7 = -1, +1>>>7 = 0
    set_rom(1, 16, 1'b0);
    x = '0;
    x[15:0] = 16'hFFFF;
    run_layer("round_neg", x, 1'b0);
    check("round_neg_const", 48'(y_out), 48'({N_OUT{16'd15}}));
    x[15:0] = 16'h0001;
    run_layer("round_pos", x, 1'b0);
    check("round_pos_const", 48'(y_out), 48'({N_OUT{16'd16}}));

    // Randomized weights, biases and activations
    for (int t = 0; t < 6; t++) begin
      set_rom(0, 0, 1'b1);
      run_layer($sformatf("rand%0d", t), rand_x(), 1'b0);
    end

    // Asynchronous abort mid-run
    set_rom(0, 0, 1'b1);
    start = 1'b1;
    x_in  = rand_x();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   48'(busy),   48'd0);
    check("abort_done",   48'(done),   48'd0);
    check("abort_y",      48'(y_out),  48'd0);
    check("abort_w_addr", 48'(w_addr), 48'd0);
    check("abort_b_addr", 48'(b_addr), 48'd0);
    prev_y = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_layer("after_abort", rand_x(), 1'b0);

    // Back-to-back: start held through the done cycle
    set_rom(0, 0, 1'b1);
    run_layer("b2b_first", rand_x(), 1'b1);
    run_layer("b2b_second", rand_x(), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
